onehot_encoder_4_to_2_hs: RTL and testbench

Registered one-hot-to-binary priority encoder, the inverse of the 2-to-4 decoder. It converts a 4-bit one-hot select back into a 2-bit code.
- Ready/valid handshake on both sides; single-entry output buffer.
- Flags malformed (multi-hot or all-zero) inputs and counts them.
- Sits between the request/select logic and the consumer of the binary code.

---
 rtl/onehot_encoder_4_to_2_hs.sv | 101 ++++++++++
 tb/tb_onehot_encoder_4_to_2_hs.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_4_to_2_hs.sv
// Registered one-hot to binary priority encoder with ready/valid on both sides.
// Define ENC_ERR_CNT_EN to build the saturating malformed-input counter; otherwise err_count reads 0.
module onehot_encoder_4_to_2_hs #(
  parameter int IN_W   = 4,
  parameter int CODE_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] code,
  output logic              multi_hot,
  output logic              zero_err,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CODE_W:0] POP_ONE = 1;

  state_t              state_q;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                multi_hot_q, multi_hot_d;
  logic                zero_err_q, zero_err_d;
  logic [CODE_W:0]     pop;
  logic                accept;

  assign in_ready = enable && ((state_q == EMPTY) || out_ready);
  assign accept   = in_valid && in_ready;

  // Later (higher) set bits overwrite earlier ones, giving MSB priority.
  always_comb begin
    code_d = '0;
    pop    = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (d[i]) begin
        code_d = i[CODE_W-1:0];
      end
      pop = pop + {{CODE_W{1'b0}}, d[i]};
    end
    multi_hot_d = (pop > POP_ONE);
    zero_err_d  = (pop == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      code_q      <= '0;
      multi_hot_q <= 1'b0;
      zero_err_q  <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q     <= FULL;
            code_q      <= code_d;
            multi_hot_q <= multi_hot_d;
            zero_err_q  <= zero_err_d;
          end
        end
        FULL: begin
          if (accept) begin
            code_q      <= code_d;
            multi_hot_q <= multi_hot_d;
            zero_err_q  <= zero_err_d;
          end else if (out_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef ENC_ERR_CNT_EN
  logic [CNT_W-1:0] err_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (accept && (multi_hot_d || zero_err_d) && (err_count_q != '1)) begin
      err_count_q <= err_count_q + 1'b1;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

  assign out_valid = (state_q == FULL);
  assign code      = code_q;
  assign multi_hot = multi_hot_q;
  assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_onehot_encoder_4_to_2_hs.sv
// Directed bench for onehot_encoder_4_to_2_hs: behavioural model checked every cycle
// plus literal expectations for the listed scenarios.
module tb_onehot_encoder_4_to_2_hs;

  localparam int IN_W   = 4;
  localparam int CODE_W = 2;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   d;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] code;
  logic              multi_hot;
  logic              zero_err;
  logic [CNT_W-1:0]  err_count;

  int checks = 0;
  int errors = 0;

  onehot_encoder_4_to_2_hs #(.IN_W(IN_W), .CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .out_valid(out_valid), .out_ready(out_ready), .code(code),
    .multi_hot(multi_hot), .zero_err(zero_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one buffered result, code = floor(log2(d)), counter saturates.
  bit m_valid;
  int m_code;
  bit m_multi;
  bit m_zero;
  int m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_code = 0; m_multi = 0; m_zero = 0; m_cnt = 0;
    end else begin
      int dv;
      dv = int'(d);
      if (in_valid && enable && (!m_valid || out_ready)) begin
        m_valid = 1;
        m_code  = (dv == 0) ? 0 : $clog2(dv + 1) - 1;
        m_multi = ($countones(dv) > 1);
        m_zero  = (dv == 0);
`ifdef ENC_ERR_CNT_EN
        if ((m_multi || m_zero) && m_cnt < CNT_MAX) m_cnt++;
`endif
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_in_ready", int'(in_ready), int'(enable && (!m_valid || out_ready)));
      check("cyc_out_valid", int'(out_valid), int'(m_valid));
      check("cyc_code", int'(code), m_code);
      check("cyc_multi_hot", int'(multi_hot), int'(m_multi));
      check("cyc_zero_err", int'(zero_err), int'(m_zero));
      check("cyc_err_count", int'(err_count), m_cnt);
    end
  end

  task automatic step(input logic en, input logic iv, input logic [IN_W-1:0] dv, input logic ordy);
    enable = en; in_valid = iv; d = dv; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_cnt(input int n);
`ifdef ENC_ERR_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  initial begin
    logic [IN_W-1:0] stream_d [4];
    stream_d[0] = 4'b1000; stream_d[1] = 4'b0001; stream_d[2] = 4'b0100; stream_d[3] = 4'b0010;

    rst_n = 0; enable = 0; in_valid = 0; d = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_code", int'(code), 0);
    check("rst_err_count", int'(err_count), 0);
    rst_n = 1;
    step(1, 0, 4'b0000, 1);

    // Single transfers
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 4'(1 << i), 1);
      check("single_valid", int'(out_valid), 1);
      check("single_code", int'(code), i);
      check("single_multi", int'(multi_hot), 0);
      check("single_zero", int'(zero_err), 0);
      step(1, 0, 4'b0000, 1);
      check("single_drain", int'(out_valid), 0);
    end

    // Back-to-back streaming
    for (int i = 0; i < 4; i++) begin
      step(1, 1, stream_d[i], 1);
      check("stream_valid", int'(out_valid), 1);
      check("stream_in_ready", int'(in_ready), 1);
    end
    check("stream_last_code", int'(code), 1);
    step(1, 0, 4'b0000, 1);

    // Backpressure
    step(1, 1, 4'b0100, 1);
    check("bp_code", int'(code), 2);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 4'b0001, 0);
      check("bp_hold_code", int'(code), 2);
      check("bp_in_ready", int'(in_ready), 0);
    end
    step(1, 1, 4'b0001, 1);
    check("bp_release_code", int'(code), 0);
    step(1, 0, 4'b0000, 1);

    // Malformed inputs
    step(1, 1, 4'b1010, 1);
    check("mal_code", int'(code), 3);
    check("mal_multi", int'(multi_hot), 1);
    check("mal_cnt1", int'(err_count), exp_cnt(1));
    step(1, 1, 4'b0000, 1);
    check("zero_code", int'(code), 0);
    check("zero_flag", int'(zero_err), 1);
    check("zero_valid", int'(out_valid), 1);
    check("mal_cnt2", int'(err_count), exp_cnt(2));
    step(1, 0, 4'b0000, 1);

    // Enable low drains but does not accept
    step(1, 1, 4'b0010, 1);
    check("en_full_code", int'(code), 1);
    step(0, 1, 4'b1000, 1);
    check("en_drained", int'(out_valid), 0);
    check("en_in_ready", int'(in_ready), 0);
    check("en_hold_code", int'(code), 1);
    step(0, 1, 4'b1000, 1);
    check("en_not_captured", int'(out_valid), 0);
    step(1, 1, 4'b1000, 1);
    check("en_recapture_valid", int'(out_valid), 1);
    check("en_recapture_code", int'(code), 3);

    // Saturation
    for (int i = 0; i < 260; i++) step(1, 1, 4'b0011, 1);
    check("sat_cnt", int'(err_count), exp_cnt(CNT_MAX));
    check("sat_code", int'(code), 1);

    // Async reset while FULL
    enable = 0; in_valid = 0; out_ready = 0;
    #2;
    rst_n = 0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_err_count", int'(err_count), 0);
    check("arst_code", int'(code), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    step(1, 1, 4'b0100, 1);
    check("post_rst_code", int'(code), 2);
    step(1, 0, 4'b0000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
